// File: rtl/pwm_ramp_ctrl.sv
// Motor PWM duty ramp controller: slews duty toward a host target, reverses via a
// controlled stop, folds back on current limit. Define PWM_RAMP_DWELL_EN to add a dwell at zero duty.
module pwm_ramp_ctrl #(
  parameter int DWELL_TICKS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       target_wr,
  input  logic [7:0] target_duty,
  input  logic       dir_req,
  input  logic [7:0] ramp_div,
  input  logic       motorena,
  input  logic       currentlimit,
  output logic [7:0] duty,
  output logic       dir,
  output logic       pwm_en,
  output logic       busy,
  output logic       ilim_active,
  output logic [2:0] state_dbg
);

  if (DWELL_TICKS < 1) begin : g_bad_dwell
    $error("DWELL_TICKS must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RAMP = 3'd1,
    HOLD = 3'd2,
    STOP = 3'd3
`ifdef PWM_RAMP_DWELL_EN
    , DWELL = 3'd4
`endif
  } state_t;

  state_t     state, next_state;
  logic [7:0] presc;
  logic [7:0] target, next_target;
  logic       target_dir, next_tdir;
  logic [7:0] next_duty;
  logic       next_dir;
  logic       presc_clr;
  logic       tick;
  logic       wr_ok;

`ifdef PWM_RAMP_DWELL_EN
  localparam int DW = $clog2(DWELL_TICKS + 1);
  logic [DW-1:0] dwell_cnt, next_dwell;
`endif

  assign tick  = (presc == ramp_div);
  assign wr_ok = target_wr && motorena;

  always_comb begin
    next_state  = state;
    next_duty   = duty;
    next_dir    = dir;
    next_target = target;
    next_tdir   = target_dir;
    presc_clr   = 1'b0;
`ifdef PWM_RAMP_DWELL_EN
    next_dwell  = dwell_cnt;
`endif
    // A write only replaces the pending target; the state logic below decides what it means.
    if (wr_ok) begin
      next_target = target_duty;
      next_tdir   = dir_req;
      presc_clr   = 1'b1;
    end
    case (state)
      IDLE: begin
        if (wr_ok && target_duty != 8'd0) begin
          next_state = RAMP;
          next_dir   = dir_req;
        end
      end
      RAMP, HOLD: begin
        if (wr_ok) begin
          if (dir_req != dir) begin
            if (duty != 8'd0) begin
              next_state = STOP;
            end else begin
              next_dir   = dir_req;
              next_state = (target_duty != 8'd0) ? RAMP : IDLE;
            end
          end else if (target_duty != duty) begin
            next_state = RAMP;
          end
        end else if (currentlimit) begin
          // Fold-back wins over any increase; RAMP afterwards recovers toward the target.
          next_state = RAMP;
          if (tick && duty != 8'd0) next_duty = duty - 8'd1;
        end else if (duty == target) begin
          next_state = (target == 8'd0) ? IDLE : HOLD;
        end else begin
          next_state = RAMP;
          if (tick) next_duty = (duty < target) ? duty + 8'd1 : duty - 8'd1;
        end
      end
      STOP: begin
        if (duty == 8'd0) begin
`ifdef PWM_RAMP_DWELL_EN
          next_state = DWELL;
          next_dwell = '0;
`else
          // The reversal takes the latest requested direction.
          next_dir   = next_tdir;
          next_state = RAMP;
`endif
        end else if (tick) begin
          next_duty = duty - 8'd1;
        end
      end
`ifdef PWM_RAMP_DWELL_EN
      DWELL: begin
        if (tick) begin
          if (dwell_cnt == DW'(DWELL_TICKS - 1)) begin
            next_dir   = next_tdir;
            next_state = RAMP;
          end else begin
            next_dwell = dwell_cnt + DW'(1);
          end
        end
      end
`endif
      default: next_state = IDLE;
    endcase
    if (!motorena) begin
      next_state  = IDLE;
      next_duty   = 8'd0;
      next_target = 8'd0;
      presc_clr   = 1'b1;
`ifdef PWM_RAMP_DWELL_EN
      next_dwell  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      duty       <= 8'd0;
      dir        <= 1'b0;
      target     <= 8'd0;
      target_dir <= 1'b0;
      presc      <= 8'd0;
    end else begin
      state      <= next_state;
      duty       <= next_duty;
      dir        <= next_dir;
      target     <= next_target;
      target_dir <= next_tdir;
      if (presc_clr || tick) presc <= 8'd0;
      else                   presc <= presc + 8'd1;
    end
  end

`ifdef PWM_RAMP_DWELL_EN
  always_ff @(posedge clk) begin
    if (reset) dwell_cnt <= '0;
    else       dwell_cnt <= next_dwell;
  end
`endif

  assign pwm_en      = motorena && (state == RAMP || state == HOLD || state == STOP);
`ifdef PWM_RAMP_DWELL_EN
  assign busy        = (state == RAMP || state == STOP || state == DWELL);
`else
  assign busy        = (state == RAMP || state == STOP);
`endif
  assign ilim_active = currentlimit && (state == RAMP || state == HOLD);
  assign state_dbg   = state;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_pwm_ramp_ctrl;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RAMP = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_STOP = 3'd3;

  logic       clk = 1'b0;
  logic       reset, target_wr, dir_req, motorena, currentlimit;
  logic [7:0] target_duty, ramp_div;
  logic [7:0] duty;
  logic       dir, pwm_en, busy, ilim_active;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int n, n_off, bad;
  logic [7:0] prev, mn;

  pwm_ramp_ctrl #(.DWELL_TICKS(64)) dut (
    .clk(clk), .reset(reset), .target_wr(target_wr), .target_duty(target_duty),
    .dir_req(dir_req), .ramp_div(ramp_div), .motorena(motorena),
    .currentlimit(currentlimit), .duty(duty), .dir(dir), .pwm_en(pwm_en),
    .busy(busy), .ilim_active(ilim_active), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] d, input logic r);
    target_duty = d;
    dir_req     = r;
    target_wr   = 1'b1;
    @(negedge clk);
    target_wr   = 1'b0;
  endtask

  task automatic wait_settle(input string tag);
    int k = 0;
    while (busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; target_wr = 1'b0; dir_req = 1'b0; motorena = 1'b1;
    currentlimit = 1'b0; target_duty = 8'd0; ramp_div = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_dir", dir, 0);
    chk("rst_pwm_en", pwm_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ilim", ilim_active, 0);
    chk("rst_state", state_dbg, S_IDLE);
    reset = 1'b0;
    @(negedge clk);

    // Ramp-up 0 -> 0x40 with ramp_div=3: 64 ticks of 4 cycles
    ramp_div = 8'd3;
    do_write(8'h40, 1'b0);
    chk("ramp_busy", busy, 1);
    chk("ramp_pwm_en", pwm_en, 1);
    n = 0;
    while (duty != 8'h40 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ramp_up_cycles_ok", (n >= 255 && n <= 257), 1);
    @(negedge clk);
    chk("hold_state", state_dbg, S_HOLD);
    chk("hold_busy", busy, 0);
    chk("hold_duty", duty, 8'h40);

    // Retarget down 0xC0 -> 0x80 at one step per cycle
    ramp_div = 8'd0;
    do_write(8'hC0, 1'b0);
    wait_settle("settle_c0");
    chk("duty_c0", duty, 8'hC0);
    do_write(8'h80, 1'b0);
    prev = duty; mn = duty; bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (!((int'(prev) - int'(duty)) inside {0, 1})) bad++;
      if (duty < mn) mn = duty;
      prev = duty;
    end
    chk("down_step_size", bad, 0);
    chk("down_min_duty", mn, 8'h80);
    chk("down_final_duty", duty, 8'h80);
    chk("down_busy", busy, 0);

    // Current-limit fold-back for 10 ticks, then recovery
    currentlimit = 1'b1;
    repeat (10) @(negedge clk);
    chk("ilim_duty", duty, 8'h76);
    chk("ilim_active", ilim_active, 1);
    chk("ilim_pwm_en", pwm_en, 1);
    currentlimit = 1'b0;
    wait_settle("settle_ilim");
    chk("ilim_recover_duty", duty, 8'h80);
    chk("ilim_released", ilim_active, 0);

    // Reversal from HOLD at 0x10, dir 0 -> 1
    do_write(8'h10, 1'b0);
    wait_settle("settle_10");
    chk("pre_rev_duty", duty, 8'h10);
    do_write(8'h10, 1'b1);
    chk("stop_state", state_dbg, S_STOP);
    chk("stop_dir_kept", dir, 0);
    n = 0;
    while (duty != 8'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stop_cycles", n, 16);
`ifdef PWM_RAMP_DWELL_EN
    n = 0; n_off = 0;
    while (dir == 1'b0 && n < 200) begin
      @(negedge clk);
      if (!pwm_en && duty == 8'd0) n_off++;
      n++;
    end
    chk("dwell_cycles_off", n_off, 64);
    chk("dwell_dir", dir, 1);
`else
    @(negedge clk);
    chk("rev_state", state_dbg, S_RAMP);
    chk("rev_dir", dir, 1);
`endif
    wait_settle("settle_rev");
    chk("rev_duty", duty, 8'h10);
    chk("rev_dir_final", dir, 1);

    // Target 0 ramps down and returns to IDLE
    do_write(8'h00, 1'b1);
    wait_settle("settle_zero");
    chk("zero_duty", duty, 0);
    chk("zero_state", state_dbg, S_IDLE);
    chk("zero_pwm_en", pwm_en, 0);

    // Enable drop mid-ramp at 0x20 with a simultaneous write
    do_write(8'h40, 1'b1);
    n = 0;
    while (duty != 8'h20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drop_reach_20", duty, 8'h20);
    motorena = 1'b0; target_wr = 1'b1; target_duty = 8'h80; dir_req = 1'b0;
    @(negedge clk);
    target_wr = 1'b0;
    chk("drop_duty", duty, 0);
    chk("drop_pwm_en", pwm_en, 0);
    chk("drop_state", state_dbg, S_IDLE);
    chk("drop_dir_kept", dir, 1);
    motorena = 1'b1;
    repeat (5) @(negedge clk);
    chk("drop_write_ignored", state_dbg, S_IDLE);
    chk("drop_duty_after", duty, 0);

    // Reset in the middle of a STOP
    do_write(8'h30, 1'b1);
    wait_settle("settle_30");
    do_write(8'h30, 1'b0);
    repeat (5) @(negedge clk);
    chk("mid_stop_state", state_dbg, S_STOP);
    chk("mid_stop_duty", duty, 8'h2B);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_duty", duty, 0);
    chk("rst2_dir", dir, 0);
    chk("rst2_pwm_en", pwm_en, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_ilim", ilim_active, 0);
    chk("rst2_state", state_dbg, S_IDLE);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst2_stays_idle", state_dbg, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
